amber48_uart_tx_fifo: RTL and testbench



---
 rtl/amber48_uart_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_amber48_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amber48_uart_tx_fifo.sv
// amber48 UART transmitter: character FIFO feeding a configurable start/data/parity/stop serialiser.
// Define AMBER48_UART_TX_BREAK_EN to add the break_i line-break generator and its BREAK state.

// Character queue for the UART transmitter.
// Head entry readable combinationally; a push is visible to the reader from the next cycle.
// No internal guarding: the caller gates push on full and pop on empty.
module amber48_uart_tx_fifo_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdat_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [$clog2(DEPTH):0] level_nxt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;

    // Depth is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        level_d  = level_q;
        if (push_i && !pop_i) begin
            level_d = level_q + 1'b1;
        end else if (!push_i && pop_i) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end

    assign rdat_o      = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign level_nxt_o = level_d;
endmodule

// Serialises queued characters onto tx_o, LSB first, every state exactly DIV cycles long.
// Start bit drives tx_o one cycle after a push into an empty idle queue; queued frames run back-to-back.
// ready_o is low while the FIFO is full, even in a cycle that pops; there is no pass-through.
module amber48_uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQ_HZ = 27_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
`ifdef AMBER48_UART_TX_BREAK_EN
    input  logic                          break_i,
`endif
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int unsigned DIV   = (CLOCK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    if (DIV < 2) begin : g_chk_div
        $error("amber48_uart_tx_fifo: clock/baud divider must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("amber48_uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_chk_par
        $error("amber48_uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("amber48_uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("amber48_uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
`ifdef AMBER48_UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 push, pop, brk, fifo_nempty, cnt_end;
    logic [DATA_BITS-1:0] fifo_rdat;
    logic [LVL_W-1:0]     level_nxt;
`ifdef AMBER48_UART_TX_BREAK_EN
    logic                 mark_q, mark_d;

    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    amber48_uart_tx_fifo_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .wdat_i      (data_i),
        .pop_i       (pop),
        .rdat_o      (fifo_rdat),
        .level_o     (level_o),
        .level_nxt_o (level_nxt)
    );

    assign ready_o     = (level_o != LVL_FULL);
    assign push        = valid_i && ready_o;
    assign fifo_nempty = (level_o != '0);
    assign cnt_end     = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef AMBER48_UART_TX_BREAK_EN
        mark_d  = mark_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
`ifdef AMBER48_UART_TX_BREAK_EN
                if (brk) begin
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    mark_d  = 1'b0;
                end else
`endif
                if (fifo_nempty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (cnt_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAR: begin
                if (cnt_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    // bit_q counts stop-bit periods here; a pending break waits in IDLE.
                    if (bit_q == STOP_LAST) begin
                        if (fifo_nempty && !brk) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef AMBER48_UART_TX_BREAK_EN
            S_BREAK: begin
                if (!mark_q) begin
                    tx_d = 1'b0;
                    if (!brk) begin
                        mark_d = 1'b1;
                        tx_d   = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (cnt_end) begin
                    mark_d = 1'b0;
                    if (fifo_nempty && !brk) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop always launches a new frame, whichever state decided it.
        if (pop) begin
            state_d = S_START;
            tx_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = fifo_rdat;
            par_d   = (PARITY == 1) ? ~^fifo_rdat : ^fifo_rdat;
        end

        busy_d = (state_d != S_IDLE) || (level_nxt != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef AMBER48_UART_TX_BREAK_EN
            mark_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef AMBER48_UART_TX_BREAK_EN
            mark_q  <= mark_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_amber48_uart_tx_fifo.sv
// Directed bench: four framing variants at DIV=10, FIFO depth 4, plus multi-cycle corner sequences.
module tb_amber48_uart_tx_fifo;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vld;
    logic [8:0] dat [4];
    logic [3:0] rdy, tx, busy;
    logic [2:0] lvl [4];
`ifdef AMBER48_UART_TX_BREAK_EN
    logic       brk;
`endif

    always #5 clk = ~clk;

    amber48_uart_tx_fifo #(.CLOCK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                           .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat[0][7:0]), .valid_i(vld[0]), .ready_o(rdy[0]),
`ifdef AMBER48_UART_TX_BREAK_EN
        .break_i(brk),
`endif
        .tx_o(tx[0]), .busy_o(busy[0]), .level_o(lvl[0]));

    amber48_uart_tx_fifo #(.CLOCK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                           .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat[1][7:0]), .valid_i(vld[1]), .ready_o(rdy[1]),
`ifdef AMBER48_UART_TX_BREAK_EN
        .break_i(1'b0),
`endif
        .tx_o(tx[1]), .busy_o(busy[1]), .level_o(lvl[1]));

    amber48_uart_tx_fifo #(.CLOCK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                           .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat[2][7:0]), .valid_i(vld[2]), .ready_o(rdy[2]),
`ifdef AMBER48_UART_TX_BREAK_EN
        .break_i(1'b0),
`endif
        .tx_o(tx[2]), .busy_o(busy[2]), .level_o(lvl[2]));

    amber48_uart_tx_fifo #(.CLOCK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                           .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat[3][6:0]), .valid_i(vld[3]), .ready_o(rdy[3]),
`ifdef AMBER48_UART_TX_BREAK_EN
        .break_i(1'b0),
`endif
        .tx_o(tx[3]), .busy_o(busy[3]), .level_o(lvl[3]));

    // bits[i] is the line level in bit period i, start bit at index 0.
    typedef struct {
        int         sel;
        logic [8:0] din;
        logic [11:0] bits;
        int         flen;
    } vec_t;

    int   nvec = 0;
    int   nmis = 0;
    logic rec_en = 1'b0;
    logic rec_tx [$];
    logic rec_bz [$];

    always @(negedge clk) begin
        if (rec_en) begin
            rec_tx.push_back(tx[0]);
            rec_bz.push_back(busy[0]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          flen;
        logic [11:0] got;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), rdy[v.sel], 1);
        dat[v.sel] = v.din;
        vld[v.sel] = 1'b1;
        @(posedge clk);
        #1 vld[v.sel] = 1'b0;
        lat = 0;
        while (tx[v.sel] !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_start_latency", idx), lat, 2);
        got  = '0;
        flen = -1;
        for (int n = 0; n < 200; n++) begin
            if (n % DIV == DIV / 2 && n / DIV < 12) got[n/DIV] = tx[v.sel];
            if (busy[v.sel] === 1'b0) begin
                flen = n;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_frame_bits", idx), got, v.bits);
        chk($sformatf("v%0d_frame_cycles", idx), flen, v.flen);
        chk($sformatf("v%0d_level_after", idx), lvl[v.sel], 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt [9];
        vt[0] = '{0, 9'h0A5, 12'h34A, 100};
        vt[1] = '{0, 9'h000, 12'h200, 100};
        vt[2] = '{0, 9'h0FF, 12'h3FE, 100};
        vt[3] = '{1, 9'h003, 12'h406, 110};
        vt[4] = '{1, 9'h001, 12'h602, 110};
        vt[5] = '{2, 9'h003, 12'hE06, 120};
        vt[6] = '{2, 9'h000, 12'hE00, 120};
        vt[7] = '{3, 9'h0FF, 12'h1FE, 90};
        vt[8] = '{3, 9'h02A, 12'h154, 90};

        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
`ifdef AMBER48_UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx%0d", i), tx[i], 1);
            chk($sformatf("rst_ready%0d", i), rdy[i], 1);
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_level%0d", i), lvl[i], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Six bytes into a depth-4 FIFO with valid held high.
        begin : t_fifo
            logic [7:0] b [6];
            logic [9:0] got_f;
            int         w, s, e, idx;
            b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            rec_tx.delete();
            rec_bz.delete();
            @(negedge clk);
            rec_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                dat[0] = {1'b0, b[i]};
                vld[0] = 1'b1;
                w = 0;
                while (rdy[0] !== 1'b1 && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                if (i == 5) chk("full_wait_cycles", w, 97);
                @(negedge clk);
                if (i == 4) begin
                    chk("full_level", lvl[0], 4);
                    chk("full_ready", rdy[0], 0);
                end
            end
            vld[0] = 1'b0;
            w = 0;
            while (busy[0] !== 1'b0 && w < 1000) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
            rec_en = 1'b0;
            s = -1;
            for (int j = 0; j < rec_tx.size(); j++) begin
                if (rec_tx[j] === 1'b0) begin
                    s = j;
                    break;
                end
            end
            chk("seq_start_seen", (s >= 0), 1);
            if (s < 0) s = 0;
            for (int f = 0; f < 6; f++) begin
                got_f = 'x;
                for (int k = 0; k < 10; k++) begin
                    idx = s + f * 100 + k * 10 + 5;
                    if (idx < rec_tx.size()) got_f[k] = rec_tx[idx];
                end
                chk($sformatf("seq_frame%0d", f), got_f, {1'b1, b[f], 1'b0});
            end
            e = -1;
            for (int j = s; j < rec_bz.size(); j++) begin
                if (rec_bz[j] === 1'b0) begin
                    e = j;
                    break;
                end
            end
            chk("seq_total_cycles", e - s, 600);
        end

        // Reset in the middle of a data bit with three bytes still queued.
        begin : t_reset
            int bad;
            @(negedge clk);
            dat[0] = 9'h000;
            vld[0] = 1'b1;
            repeat (4) @(negedge clk);
            vld[0] = 1'b0;
            repeat (30) @(negedge clk);
            chk("pre_rst_level", lvl[0], 3);
            chk("pre_rst_tx", tx[0], 0);
            rst_n = 1'b0;
            @(negedge clk);
            chk("mid_rst_tx", tx[0], 1);
            chk("mid_rst_level", lvl[0], 0);
            chk("mid_rst_busy", busy[0], 0);
            chk("mid_rst_ready", rdy[0], 1);
            rst_n = 1'b1;
            bad = 0;
            repeat (300) begin
                @(negedge clk);
                if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
            end
            chk("post_rst_quiet", bad, 0);
        end

`ifdef AMBER48_UART_TX_BREAK_EN
        begin : t_break
            int lat, hi, c;
            @(negedge clk);
            dat[0] = 9'h055;
            vld[0] = 1'b1;
            @(negedge clk);
            vld[0] = 1'b0;
            lat = 0;
            while (tx[0] !== 1'b0 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("brk_frame_started", lat, 1);
            hi = 0;
            for (int n = 0; n < 160; n++) begin
                if (n == 30) brk = 1'b1;
                if (n == 95) chk("brk_stop_bit", tx[0], 1);
                if (n == 100) chk("brk_frame_end_high", tx[0], 1);
                if (n == 102) chk("brk_entered", tx[0], 0);
                if (n > 102 && tx[0] !== 1'b0) hi++;
                if (n == 110) begin
                    dat[0] = 9'h00F;
                    vld[0] = 1'b1;
                end
                if (n == 111) vld[0] = 1'b0;
                if (n == 150) chk("brk_push_accepted", lvl[0], 1);
                @(negedge clk);
            end
            chk("brk_held_low", hi, 0);
            brk = 1'b0;
            c = 0;
            @(negedge clk);
            while (tx[0] === 1'b1 && c < 50) begin
                c++;
                @(negedge clk);
            end
            chk("brk_mark_cycles", c, 10);
            c = 0;
            while (busy[0] !== 1'b0 && c < 300) begin
                @(negedge clk);
                c++;
            end
            chk("brk_queued_frame_done", busy[0], 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
